seg_disp_arbiter: RTL and testbench

Shares the 4-digit seven-segment display between the always-present base value (score) and two event requesters (e.g. level number, lives/bonus). It grants the display to one requester at a time for a fixed hold period, acknowledges each grant, and falls back to the base value when idle. It drives the `disp_num`/`dpdot` inputs of the seven-segment scan driver, saturating values so the 4 decimal digits never wrap.

---
 rtl/seg_disp_arbiter.sv | 100 ++++++++++
 tb/tb_seg_disp_arbiter.sv | 213 +++++++++++++++++++++
 2 files changed

// File: rtl/seg_disp_arbiter.sv
// Seven-segment display arbiter: base value vs. two timed requesters.
// Grants one requester at a time for HOLD_CYCLES, saturating shown values at 9999.
module seg_disp_arbiter #(
    parameter int HOLD_W      = 26,
    parameter int HOLD_CYCLES = 50_000_000
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [15:0] base_num,
    input  logic [3:0]  base_dot,
    input  logic [1:0]  req,
    input  logic [15:0] req_num0,
    input  logic [15:0] req_num1,
    input  logic [3:0]  req_dot0,
    input  logic [3:0]  req_dot1,
    output logic [1:0]  ack,
    output logic [15:0] disp_num,
    output logic [3:0]  dpdot,
    output logic [1:0]  owner,
    output logic        busy,
    output logic        sat
);

    localparam logic [0:0] ST_IDLE = 1'b0;
    localparam logic [0:0] ST_SHOW = 1'b1;

    localparam logic [15:0]       LP_MAX  = 16'd9999;
    localparam logic [HOLD_W-1:0] LP_LOAD = HOLD_W'(HOLD_CYCLES - 1);

    logic [0:0]        r_state;
    logic [HOLD_W-1:0] r_cnt;
    logic              r_last;
    logic [1:0]        r_ack;
    logic [15:0]       r_num;
    logic [3:0]        r_dot;
    logic [1:0]        r_owner;
    logic              r_busy;
    logic              r_sat;

    logic        w_any;
    logic        w_pick1;
    logic [15:0] w_gnum;
    logic [3:0]  w_gdot;
    logic        w_expired;

    function automatic logic [15:0] f_clamp(input logic [15:0] v);
        return (v > LP_MAX) ? LP_MAX : v;
    endfunction

    // req0 wins a tie only when the previous grant went to req1
    assign w_any     = |req;
    assign w_pick1   = req[1] && !(req[0] && r_last);
    assign w_gnum    = w_pick1 ? req_num1 : req_num0;
    assign w_gdot    = w_pick1 ? req_dot1 : req_dot0;
    assign w_expired = (r_cnt == '0);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ST_IDLE;
            r_cnt   <= '0;
            r_last  <= 1'b0;
            r_ack   <= 2'b00;
            r_num   <= 16'd0;
            r_dot   <= 4'd0;
            r_owner <= 2'd0;
            r_busy  <= 1'b0;
            r_sat   <= 1'b0;
        end else begin
            r_ack <= 2'b00;
            if ((r_state == ST_IDLE || w_expired) && w_any) begin
                r_state <= ST_SHOW;
                r_cnt   <= LP_LOAD;
                r_last  <= w_pick1;
                r_ack   <= w_pick1 ? 2'b10 : 2'b01;
                r_num   <= f_clamp(w_gnum);
                r_dot   <= w_gdot;
                r_sat   <= (w_gnum > LP_MAX);
                r_owner <= w_pick1 ? 2'd2 : 2'd1;
                r_busy  <= 1'b1;
            end else if (r_state == ST_IDLE || w_expired) begin
                r_state <= ST_IDLE;
                r_num   <= f_clamp(base_num);
                r_dot   <= base_dot;
                r_sat   <= (base_num > LP_MAX);
                r_owner <= 2'd0;
                r_busy  <= 1'b0;
            end else begin
                r_cnt <= r_cnt - 1'b1;
            end
        end
    end

    assign ack      = r_ack;
    assign disp_num = r_num;
    assign dpdot    = r_dot;
    assign owner    = r_owner;
    assign busy     = r_busy;
    assign sat      = r_sat;

endmodule

// File: tb/tb_seg_disp_arbiter.sv
// Directed bench for seg_disp_arbiter with HOLD_CYCLES=4.
// Observed tuple: {ack, owner, busy, sat, disp_num, dpdot}.
module tb_seg_disp_arbiter;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [15:0] base_num;
    logic [3:0]  base_dot;
    logic [1:0]  req;
    logic [15:0] req_num0, req_num1;
    logic [3:0]  req_dot0, req_dot1;
    logic [1:0]  ack;
    logic [15:0] disp_num;
    logic [3:0]  dpdot;
    logic [1:0]  owner;
    logic        busy;
    logic        sat;
    logic [25:0] w_obs;
    logic [25:0] exp_v;
    int          n_vec = 0;
    int          n_err = 0;

    always #5 clk = ~clk;

    seg_disp_arbiter #(.HOLD_W(8), .HOLD_CYCLES(4)) dut (
        .clk(clk), .rst_n(rst_n),
        .base_num(base_num), .base_dot(base_dot),
        .req(req),
        .req_num0(req_num0), .req_num1(req_num1),
        .req_dot0(req_dot0), .req_dot1(req_dot1),
        .ack(ack), .disp_num(disp_num), .dpdot(dpdot),
        .owner(owner), .busy(busy), .sat(sat)
    );

    assign w_obs = {ack, owner, busy, sat, disp_num, dpdot};

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // 4'b0100 is the base dot pattern, 0001 req0, 1000 req1
    function automatic logic [25:0] e_base(input logic [15:0] n, input logic s);
        return {2'b00, 2'd0, 1'b0, s, n, 4'b0100};
    endfunction

    function automatic logic [25:0] e_show(input logic [1:0] a, input logic [1:0] o,
                                           input logic s, input logic [15:0] n);
        return {a, o, 1'b1, s, n, (o == 2'd2) ? 4'b1000 : 4'b0001};
    endfunction

    task automatic chk(input string name, input logic [25:0] e);
        n_vec++;
        if (w_obs !== e) begin
            n_err++;
            $display("FAIL %s got %h want %h", name, w_obs, e);
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0; req = 2'b00;
        base_num = 16'd1234; base_dot = 4'b0100;
        req_num0 = 16'd7; req_dot0 = 4'b0001;
        req_num1 = 16'd5555; req_dot1 = 4'b1000;
        #12;
        n_vec++;
        if (w_obs !== 26'd0) begin
            n_err++; $display("FAIL reset_vals got %h want 0", w_obs);
        end
        rst_n = 1'b1;
        tick();
        chk("idle_base", e_base(16'd1234, 1'b0));
        tick();
        rst_n = 1'b0;
        #1;
        n_vec++;
        if (w_obs !== 26'd0) begin
            n_err++; $display("FAIL async_reset got %h want 0", w_obs);
        end
        #2 rst_n = 1'b1;
        tick();
        chk("post_reset", e_base(16'd1234, 1'b0));
    endtask

    task automatic test_single();
        req = 2'b01;
        tick();
        chk("single_grant", e_show(2'b01, 2'd1, 1'b0, 16'd7));
        req = 2'b00;
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("single_hold", e_show(2'b00, 2'd1, 1'b0, 16'd7));
        end
        tick();
        chk("single_expire", e_base(16'd1234, 1'b0));
    endtask

    task automatic test_back_to_back();
        req = 2'b11;
        tick();
        chk("both_first_r1", e_show(2'b10, 2'd2, 1'b0, 16'd5555));
        req = 2'b01;
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("both_hold_r1", e_show(2'b00, 2'd2, 1'b0, 16'd5555));
        end
        tick();
        chk("both_then_r0", e_show(2'b01, 2'd1, 1'b0, 16'd7));
        req = 2'b00;
        for (int i = 0; i < 3; i++) tick();
        chk("both_last_hold", e_show(2'b00, 2'd1, 1'b0, 16'd7));
        tick();
        chk("both_idle", e_base(16'd1234, 1'b0));
    endtask

    task automatic test_alternate();
        req = 2'b11;
        tick();
        chk("alt_r1_a", e_show(2'b10, 2'd2, 1'b0, 16'd5555));
        for (int i = 0; i < 3; i++) tick();
        chk("alt_r1_a_hold", e_show(2'b00, 2'd2, 1'b0, 16'd5555));
        tick();
        chk("alt_r0", e_show(2'b01, 2'd1, 1'b0, 16'd7));
        req = 2'b10;
        for (int i = 0; i < 3; i++) tick();
        tick();
        chk("alt_r1_b", e_show(2'b10, 2'd2, 1'b0, 16'd5555));
        req = 2'b00;
        for (int i = 0; i < 3; i++) tick();
        tick();
        chk("alt_idle", e_base(16'd1234, 1'b0));
    endtask

    task automatic test_saturation();
        base_num = 16'd65535;
        tick();
        chk("sat_base", e_base(16'd9999, 1'b1));
        base_num = 16'd1234;
        tick();
        chk("unsat_base", e_base(16'd1234, 1'b0));
        req_num1 = 16'd12000; req = 2'b10;
        tick();
        chk("sat_req1", e_show(2'b10, 2'd2, 1'b1, 16'd9999));
        req = 2'b00;
        for (int i = 0; i < 4; i++) tick();
        chk("sat_clear", e_base(16'd1234, 1'b0));
        req_num1 = 16'd5555;
    endtask

    task automatic test_no_preempt();
        req = 2'b01;
        tick();
        chk("np_r0", e_show(2'b01, 2'd1, 1'b0, 16'd7));
        req = 2'b10;
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("np_hold", e_show(2'b00, 2'd1, 1'b0, 16'd7));
        end
        tick();
        chk("np_r1", e_show(2'b10, 2'd2, 1'b0, 16'd5555));
        req = 2'b00;
        for (int i = 0; i < 4; i++) tick();
        chk("np_idle", e_base(16'd1234, 1'b0));
    endtask

    task automatic test_withdraw();
        req = 2'b01;
        tick();
        chk("wd_r0", e_show(2'b01, 2'd1, 1'b0, 16'd7));
        req = 2'b10;
        tick();
        req = 2'b00;
        for (int i = 0; i < 2; i++) begin
            tick();
            chk("wd_hold", e_show(2'b00, 2'd1, 1'b0, 16'd7));
        end
        tick();
        chk("wd_idle", e_base(16'd1234, 1'b0));
        tick();
        chk("wd_no_ack", e_base(16'd1234, 1'b0));
    endtask

    task automatic test_reset_mid_show();
        req = 2'b01;
        tick();
        chk("mid_grant", e_show(2'b01, 2'd1, 1'b0, 16'd7));
        req = 2'b00;
        tick();
        rst_n = 1'b0;
        #1;
        n_vec++;
        if (w_obs !== 26'd0) begin
            n_err++; $display("FAIL mid_show_reset got %h want 0", w_obs);
        end
        #2 rst_n = 1'b1;
        tick();
        chk("mid_recover", e_base(16'd1234, 1'b0));
    endtask

    initial begin
        test_reset();
        test_single();
        test_back_to_back();
        test_alternate();
        test_saturation();
        test_no_preempt();
        test_withdraw();
        test_reset_mid_show();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
